memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- MEM stage directly downstream of the execute stage; consumes the EX/MEM buffered outputs and drives the MEM/WB buffer.
- Owns the data memory, the stack pointer (SP), and a multi-cycle stack sequencer for CALL/RET/INT/RTI (32-bit PC = two 16-bit words).
- Returns a stall to upstream stages, a popped/vector PC to fetch, and popped flags to the ALU (conditions_from_memory_pop).

Parameters:
- ADDR_W, 11, data memory address width; depth 2^ADDR_W words of 16 bits.
- INT_VEC_ADDR, 0, address of the interrupt vector: hi word at INT_VEC_ADDR, lo word at INT_VEC_ADDR+1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- alu_result  in  16  EX result; data address when memory_address_select=0.
- read_data1  in  16  forwarded Rdest operand; store/push data.
- read_data2  in  16  forwarded Rsrc operand; data address when memory_address_select=1.
- ldm_value, inport_value  in  16 each  passed through to WB.
- mem_read, mem_write  in  1 each  plain load/store.
- memory_address_select  in  2  0=alu_result, 1=read_data2, 2/3 reserved (treated as 0).
- stack_op  in  3  0 NONE, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 INT, 6 RTI, 7 reserved (treated as NONE).
- pc_plus_one  in  32  return address for CALL/INT.
- flag_register  in  3  {C,N,Z}, pushed by INT.
- reg_write, outport_enable  in  1 each; reg_write_address  in  3; wb_sel  in  2  passed through.
- stall  out  1  combinational; upstream holds all inputs while high.
- mem_data_out, alu_result_out, ldm_value_out, inport_value_out  out  16 each  MEM/WB registers.
- reg_write_out, outport_enable_out  out  1 each; reg_write_address_out  out  3; wb_sel_out  out  2.
- pc_from_memory  out  32; pc_from_memory_valid  out  1  one-cycle pulse.
- conditions_from_memory_pop  out  3; flags_pop_valid  out  1  one-cycle pulse.
- sp_out  out  ADDR_W  current SP.

Behaviour:
- Reset (reset=0, async): SP=2^ADDR_W-1, FSM=IDLE, all registered outputs 0, stall=0. Memory contents are not cleared. Reset mid-sequence aborts the sequence; any words already written stay in memory.
- Memory: synchronous write on posedge, asynchronous read; addresses are truncated to the low ADDR_W bits.
- Load: mem_data_out <= mem[addr] (1-cycle latency). Store: mem[addr] <= read_data1. If mem_read and mem_write are both 1, the write is performed and mem_data_out returns the pre-write value.
- stack_op != NONE overrides mem_read/mem_write.
- Stack discipline: push writes mem[SP], then SP-1. Pop sets SP+1, then reads mem[SP+1]. SP arithmetic wraps modulo 2^ADDR_W (push at 0 -> SP becomes 2^ADDR_W-1; pop at 2^ADDR_W-1 -> SP becomes 0). No overflow detection.
- PUSH / POP: 1 cycle, stall=0. POP data goes to mem_data_out.
- FSM states: IDLE, PUSH_LO, PUSH_FLG, VEC_HI, VEC_LO, POP_LO, POP_HI.
  - CALL: IDLE pushes pc[31:16] -> PUSH_LO pushes pc[15:0] -> IDLE. 2 cycles. pc_from_memory_valid stays 0; EX supplies the branch target.
  - INT: IDLE pushes pc hi -> PUSH_LO pushes pc lo -> PUSH_FLG pushes {13'b0,flag_register} -> VEC_HI reads mem[INT_VEC_ADDR] -> VEC_LO reads mem[INT_VEC_ADDR+1]. Then pc_from_memory={hi,lo} with valid pulse -> IDLE. 5 cycles.
  - RET: IDLE pops lo -> POP_HI pops hi. pc_from_memory={hi,lo} with valid -> IDLE. 2 cycles.
  - RTI: IDLE pops flags. Popped bits [2:0] go to conditions_from_memory_pop with flags_pop_valid pulse. Then -> POP_LO -> POP_HI -> valid PC -> IDLE. 3 cycles.
- stall=1 in every cycle of a multi-cycle op except its final cycle; stall=0 in IDLE for NONE/PUSH/POP.
- Pipeline registers capture inputs only on the final cycle of an op. Non-final cycles load a bubble: reg_write_out=0 and outport_enable_out=0.
- Inputs must stay stable while stall=1. stack_op is sampled only in IDLE.

Test Plan:
- Reset release: SP=2047, all outputs 0. Then store read_data1=0xBEEF at alu_result=0x0010, load 0x0010 -> mem_data_out=0xBEEF one cycle later.
- PUSH 0x1234, PUSH 0x5678, POP, POP -> sp_out 2047,2046,2045,2046,2047. Pops return 0x5678 then 0x1234.
- CALL with pc_plus_one=0x0001_0042 -> stall=1 for 1 cycle, mem[2047]=0x0001, mem[2046]=0x0042, SP=2045. Following RET -> pc_from_memory=0x0001_0042, valid pulse in cycle 2, SP=2047.
- mem[0]=0x0000, mem[1]=0x0100. INT with pc_plus_one=0x20, flags=3'b101 -> stall for 4 cycles, pc_from_memory=0x0000_0100. RTI -> conditions_from_memory_pop=3'b101, then pc_from_memory=0x20, SP back to 2047.
- Wrap: with SP=0, PUSH 0xAAAA -> mem[0]=0xAAAA, SP=2047. POP -> SP=0, data 0xAAAA.
- Assert reset during PUSH_FLG of INT -> immediately SP=2047, stall=0, valid outputs 0. mem[2047] and mem[2046] keep the pushed PC words.

Source files
------------

// File: rtl/memory_stage.sv
// MEM pipeline stage: data memory, stack pointer and the multi-cycle stack
// sequencer for CALL/RET/INT/RTI. Drives the MEM/WB registers and returns
// stall, popped PC and popped flags to the upstream stages.
module memory_stage #(
    parameter int ADDR_W       = 11,
    parameter int INT_VEC_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       alu_result,
    input  logic [15:0]       read_data1,
    input  logic [15:0]       read_data2,
    input  logic [15:0]       ldm_value,
    input  logic [15:0]       inport_value,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        memory_address_select,
    input  logic [2:0]        stack_op,
    input  logic [31:0]       pc_plus_one,
    input  logic [2:0]        flag_register,
    input  logic              reg_write,
    input  logic              outport_enable,
    input  logic [2:0]        reg_write_address,
    input  logic [1:0]        wb_sel,
    output logic              stall,
    output logic [15:0]       mem_data_out,
    output logic [15:0]       alu_result_out,
    output logic [15:0]       ldm_value_out,
    output logic [15:0]       inport_value_out,
    output logic              reg_write_out,
    output logic              outport_enable_out,
    output logic [2:0]        reg_write_address_out,
    output logic [1:0]        wb_sel_out,
    output logic [31:0]       pc_from_memory,
    output logic              pc_from_memory_valid,
    output logic [2:0]        conditions_from_memory_pop,
    output logic              flags_pop_valid,
    output logic [ADDR_W-1:0] sp_out
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] VEC_HI_ADDR = ADDR_W'(INT_VEC_ADDR);
    localparam logic [ADDR_W-1:0] VEC_LO_ADDR = ADDR_W'(INT_VEC_ADDR + 1);

    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_INT  = 3'd5;
    localparam logic [2:0] OP_RTI  = 3'd6;

    typedef enum logic [2:0] {
        IDLE, PUSH_LO, PUSH_FLG, VEC_HI, VEC_LO, POP_LO, POP_HI
    } state_t;

    state_t            state, state_nxt;
    logic              op_is_int, op_is_int_nxt;
    logic [ADDR_W-1:0] sp, sp_nxt, sp_inc, sp_dec;
    logic [ADDR_W-1:0] data_addr, raddr, waddr;
    logic              mem_we, rd_en;
    logic [15:0]       wdata, rd_data;
    logic [15:0]       pc_lo_hold, pc_hi_hold;
    logic [15:0]       mem [0:DEPTH-1];

    // Upper address bits are intentionally dropped by the truncating decode.
    logic unused_ok;
    assign unused_ok = ^read_data2[15:ADDR_W];

    assign data_addr = (memory_address_select == 2'd1) ? read_data2[ADDR_W-1:0]
                                                       : alu_result[ADDR_W-1:0];
    assign sp_inc  = sp + ADDR_W'(1);
    assign sp_dec  = sp - ADDR_W'(1);
    assign rd_data = mem[raddr];
    assign sp_out  = sp;

    // Sequencer: per-state memory access, SP update, stall and next state.
    always_comb begin
        state_nxt     = state;
        op_is_int_nxt = op_is_int;
        sp_nxt        = sp;
        stall         = 1'b0;
        mem_we        = 1'b0;
        rd_en         = 1'b0;
        waddr         = sp;
        wdata         = read_data1;
        raddr         = data_addr;
        case (state)
            IDLE: begin
                case (stack_op)
                    OP_PUSH: begin
                        mem_we = 1'b1;
                        sp_nxt = sp_dec;
                    end
                    OP_POP: begin
                        sp_nxt = sp_inc;
                        raddr  = sp_inc;
                        rd_en  = 1'b1;
                    end
                    OP_CALL, OP_INT: begin
                        mem_we        = 1'b1;
                        wdata         = pc_plus_one[31:16];
                        sp_nxt        = sp_dec;
                        stall         = 1'b1;
                        op_is_int_nxt = (stack_op == OP_INT);
                        state_nxt     = PUSH_LO;
                    end
                    OP_RET: begin
                        sp_nxt    = sp_inc;
                        raddr     = sp_inc;
                        stall     = 1'b1;
                        state_nxt = POP_HI;
                    end
                    OP_RTI: begin
                        sp_nxt    = sp_inc;
                        raddr     = sp_inc;
                        stall     = 1'b1;
                        state_nxt = POP_LO;
                    end
                    default: begin
                        // NONE and the reserved encoding behave as plain load/store.
                        mem_we = mem_write;
                        waddr  = data_addr;
                        rd_en  = mem_read;
                    end
                endcase
            end
            PUSH_LO: begin
                mem_we = 1'b1;
                wdata  = pc_plus_one[15:0];
                sp_nxt = sp_dec;
                if (op_is_int) begin
                    stall     = 1'b1;
                    state_nxt = PUSH_FLG;
                end else begin
                    state_nxt = IDLE;
                end
            end
            PUSH_FLG: begin
                mem_we    = 1'b1;
                wdata     = {13'b0, flag_register};
                sp_nxt    = sp_dec;
                stall     = 1'b1;
                state_nxt = VEC_HI;
            end
            VEC_HI: begin
                raddr     = VEC_HI_ADDR;
                stall     = 1'b1;
                state_nxt = VEC_LO;
            end
            VEC_LO: begin
                raddr     = VEC_LO_ADDR;
                state_nxt = IDLE;
            end
            POP_LO: begin
                sp_nxt    = sp_inc;
                raddr     = sp_inc;
                stall     = 1'b1;
                state_nxt = POP_HI;
            end
            POP_HI: begin
                sp_nxt    = sp_inc;
                raddr     = sp_inc;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: FSM, SP and the CALL/INT discriminator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sp        <= '1;
            op_is_int <= 1'b0;
        end else begin
            state     <= state_nxt;
            sp        <= sp_nxt;
            op_is_int <= op_is_int_nxt;
        end
    end

    // Data memory write port; a write is never committed while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && reset)
            mem[waddr] <= wdata;
    end

    // Holding registers for the first popped/vector word of a two-word PC.
    always_ff @(posedge clk) begin
        if (state == IDLE && stack_op == OP_RET)
            pc_lo_hold <= rd_data;
        if (state == POP_LO)
            pc_lo_hold <= rd_data;
        if (state == VEC_HI)
            pc_hi_hold <= rd_data;
    end

    // MEM/WB registers plus PC/flag return paths; bubbles while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_data_out               <= '0;
            alu_result_out             <= '0;
            ldm_value_out              <= '0;
            inport_value_out           <= '0;
            reg_write_out              <= 1'b0;
            outport_enable_out         <= 1'b0;
            reg_write_address_out      <= '0;
            wb_sel_out                 <= '0;
            pc_from_memory             <= '0;
            pc_from_memory_valid       <= 1'b0;
            conditions_from_memory_pop <= '0;
            flags_pop_valid            <= 1'b0;
        end else begin
            pc_from_memory_valid <= 1'b0;
            flags_pop_valid      <= 1'b0;
            if (stall) begin
                reg_write_out      <= 1'b0;
                outport_enable_out <= 1'b0;
            end else begin
                mem_data_out          <= rd_en ? rd_data : 16'h0000;
                alu_result_out        <= alu_result;
                ldm_value_out         <= ldm_value;
                inport_value_out      <= inport_value;
                reg_write_out         <= reg_write;
                outport_enable_out    <= outport_enable;
                reg_write_address_out <= reg_write_address;
                wb_sel_out            <= wb_sel;
            end
            if (state == IDLE && stack_op == OP_RTI) begin
                conditions_from_memory_pop <= rd_data[2:0];
                flags_pop_valid            <= 1'b1;
            end
            if (state == VEC_LO) begin
                pc_from_memory       <= {pc_hi_hold, rd_data};
                pc_from_memory_valid <= 1'b1;
            end
            if (state == POP_HI) begin
                pc_from_memory       <= {rd_data, pc_lo_hold};
                pc_from_memory_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: vector table for single-cycle operations,
// hand-written sequences for CALL/RET/INT/RTI and mid-sequence reset.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] alu_result, read_data1, read_data2, ldm_value, inport_value;
    logic        mem_read, mem_write;
    logic [1:0]  memory_address_select;
    logic [2:0]  stack_op;
    logic [31:0] pc_plus_one;
    logic [2:0]  flag_register;
    logic        reg_write, outport_enable;
    logic [2:0]  reg_write_address;
    logic [1:0]  wb_sel;
    logic        stall;
    logic [15:0] mem_data_out, alu_result_out, ldm_value_out, inport_value_out;
    logic        reg_write_out, outport_enable_out;
    logic [2:0]  reg_write_address_out;
    logic [1:0]  wb_sel_out;
    logic [31:0] pc_from_memory;
    logic        pc_from_memory_valid;
    logic [2:0]  conditions_from_memory_pop;
    logic        flags_pop_valid;
    logic [10:0] sp_out;

    int passed = 0;
    int total  = 0;

    memory_stage #(.ADDR_W(11), .INT_VEC_ADDR(0)) dut (
        .clk(clk), .reset(reset),
        .alu_result(alu_result), .read_data1(read_data1), .read_data2(read_data2),
        .ldm_value(ldm_value), .inport_value(inport_value),
        .mem_read(mem_read), .mem_write(mem_write),
        .memory_address_select(memory_address_select), .stack_op(stack_op),
        .pc_plus_one(pc_plus_one), .flag_register(flag_register),
        .reg_write(reg_write), .outport_enable(outport_enable),
        .reg_write_address(reg_write_address), .wb_sel(wb_sel),
        .stall(stall), .mem_data_out(mem_data_out), .alu_result_out(alu_result_out),
        .ldm_value_out(ldm_value_out), .inport_value_out(inport_value_out),
        .reg_write_out(reg_write_out), .outport_enable_out(outport_enable_out),
        .reg_write_address_out(reg_write_address_out), .wb_sel_out(wb_sel_out),
        .pc_from_memory(pc_from_memory), .pc_from_memory_valid(pc_from_memory_valid),
        .conditions_from_memory_pop(conditions_from_memory_pop),
        .flags_pop_valid(flags_pop_valid), .sp_out(sp_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        rd;
        logic        wr;
        logic        sel;
        logic [15:0] alu;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic        rw;
        logic [10:0] exp_sp;
        logic        chk_md;
        logic [15:0] exp_md;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stack_op  = 3'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        memory_address_select = 2'd0;
        reg_write = 1'b0;
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] d);
        idle_inputs();
        alu_result = a;
        read_data1 = d;
        mem_write  = 1'b1;
        cycle();
        mem_write  = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] a, output logic [15:0] d);
        idle_inputs();
        alu_result = a;
        mem_read   = 1'b1;
        cycle();
        d = mem_data_out;
        mem_read = 1'b0;
    endtask

    logic [15:0] ld;
    int          n;

    initial begin
        vecs[0]  = '{3'd0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 11'd2047, 1'b0, 16'h0000};
        vecs[1]  = '{3'd0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b1, 11'd2047, 1'b1, 16'hBEEF};
        vecs[2]  = '{3'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000, 1'b0, 11'd2046, 1'b0, 16'h0000};
        vecs[3]  = '{3'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5678, 16'h0000, 1'b0, 11'd2045, 1'b0, 16'h0000};
        vecs[4]  = '{3'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 11'd2046, 1'b1, 16'h5678};
        vecs[5]  = '{3'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 11'd2047, 1'b1, 16'h1234};
        vecs[6]  = '{3'd0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h1111, 16'h0000, 1'b0, 11'd2047, 1'b1, 16'hBEEF};
        vecs[7]  = '{3'd0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b1, 11'd2047, 1'b1, 16'h1111};
        vecs[8]  = '{3'd0, 1'b1, 1'b0, 1'b0, 16'h0810, 16'h0000, 16'h0000, 1'b0, 11'd2047, 1'b1, 16'h1111};
        vecs[9]  = '{3'd0, 1'b1, 1'b0, 1'b1, 16'h0555, 16'h0000, 16'h0010, 1'b1, 11'd2047, 1'b1, 16'h1111};
        vecs[10] = '{3'd7, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0, 11'd2047, 1'b1, 16'h1111};
        vecs[11] = '{3'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 11'd0,    1'b0, 16'h0000};
        vecs[12] = '{3'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hAAAA, 16'h0000, 1'b0, 11'd2047, 1'b0, 16'h0000};
        vecs[13] = '{3'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 11'd0,    1'b1, 16'hAAAA};
        vecs[14] = '{3'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h7777, 16'h0000, 1'b0, 11'd2047, 1'b0, 16'h0000};

        reset = 1'b0;
        alu_result = '0; read_data1 = '0; read_data2 = '0;
        ldm_value = '0; inport_value = '0;
        pc_plus_one = '0; flag_register = '0;
        outport_enable = 1'b0; reg_write_address = '0; wb_sel = '0;
        idle_inputs();

        // Reset state
        cycle();
        cycle();
        chk("rst_sp", 32'(sp_out), 32'd2047);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_md", 32'(mem_data_out), 32'd0);
        chk("rst_pcv", 32'(pc_from_memory_valid), 32'd0);
        chk("rst_rw", 32'(reg_write_out), 32'd0);
        reset = 1'b1;
        cycle();

        // Single-cycle operations from the vector table
        for (int i = 0; i < 15; i++) begin
            stack_op   = vecs[i].op;
            mem_read   = vecs[i].rd;
            mem_write  = vecs[i].wr;
            memory_address_select = {1'b0, vecs[i].sel};
            alu_result = vecs[i].alu;
            read_data1 = vecs[i].rd1;
            read_data2 = vecs[i].rd2;
            reg_write  = vecs[i].rw;
            reg_write_address = 3'(i);
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
            cycle();
            chk($sformatf("vec%0d_sp", i), 32'(sp_out), 32'(vecs[i].exp_sp));
            chk($sformatf("vec%0d_rw", i), 32'(reg_write_out), 32'(vecs[i].rw));
            if (vecs[i].chk_md)
                chk($sformatf("vec%0d_md", i), 32'(mem_data_out), 32'(vecs[i].exp_md));
        end
        idle_inputs();

        // CALL then RET
        stack_op = 3'd3; pc_plus_one = 32'h0001_0042; reg_write = 1'b1;
        #1;
        chk("call_stall0", 32'(stall), 32'd1);
        cycle();
        chk("call_bubble", 32'(reg_write_out), 32'd0);
        chk("call_sp1", 32'(sp_out), 32'd2046);
        chk("call_stall1", 32'(stall), 32'd0);
        cycle();
        chk("call_sp2", 32'(sp_out), 32'd2045);
        chk("call_rw", 32'(reg_write_out), 32'd1);
        chk("call_pcv", 32'(pc_from_memory_valid), 32'd0);
        idle_inputs();
        do_load(16'd2047, ld); chk("call_hi_word", 32'(ld), 32'h0001);
        do_load(16'd2046, ld); chk("call_lo_word", 32'(ld), 32'h0042);
        stack_op = 3'd4;
        #1;
        chk("ret_stall0", 32'(stall), 32'd1);
        cycle();
        chk("ret_stall1", 32'(stall), 32'd0);
        chk("ret_pcv_early", 32'(pc_from_memory_valid), 32'd0);
        cycle();
        chk("ret_pcv", 32'(pc_from_memory_valid), 32'd1);
        chk("ret_pc", pc_from_memory, 32'h0001_0042);
        chk("ret_sp", 32'(sp_out), 32'd2047);
        idle_inputs();
        cycle();
        chk("ret_pcv_pulse", 32'(pc_from_memory_valid), 32'd0);

        // INT then RTI
        do_store(16'd0, 16'h0000);
        do_store(16'd1, 16'h0100);
        stack_op = 3'd5; pc_plus_one = 32'h0000_0020; flag_register = 3'b101;
        #1;
        n = 0;
        while (stall && n < 10) begin
            cycle();
            n++;
        end
        chk("int_stall_cycles", 32'(n), 32'd4);
        cycle();
        chk("int_pcv", 32'(pc_from_memory_valid), 32'd1);
        chk("int_pc", pc_from_memory, 32'h0000_0100);
        chk("int_sp", 32'(sp_out), 32'd2044);
        idle_inputs();
        do_load(16'd2045, ld); chk("int_flag_word", 32'(ld), 32'h0005);
        do_load(16'd2046, ld); chk("int_lo_word", 32'(ld), 32'h0020);
        stack_op = 3'd6;
        #1;
        chk("rti_stall0", 32'(stall), 32'd1);
        cycle();
        chk("rti_fv", 32'(flags_pop_valid), 32'd1);
        chk("rti_flags", 32'(conditions_from_memory_pop), 32'b101);
        chk("rti_stall1", 32'(stall), 32'd1);
        cycle();
        chk("rti_fv_pulse", 32'(flags_pop_valid), 32'd0);
        chk("rti_stall2", 32'(stall), 32'd0);
        cycle();
        chk("rti_pcv", 32'(pc_from_memory_valid), 32'd1);
        chk("rti_pc", pc_from_memory, 32'h0000_0020);
        chk("rti_sp", 32'(sp_out), 32'd2047);
        idle_inputs();
        cycle();

        // Reset asserted while INT is in PUSH_FLG
        stack_op = 3'd5; pc_plus_one = 32'h0003_0004; flag_register = 3'b011;
        cycle();
        cycle();
        chk("mid_sp_before", 32'(sp_out), 32'd2045);
        reset = 1'b0;
        idle_inputs();
        #1;
        chk("mid_sp", 32'(sp_out), 32'd2047);
        chk("mid_stall", 32'(stall), 32'd0);
        chk("mid_pcv", 32'(pc_from_memory_valid), 32'd0);
        chk("mid_fv", 32'(flags_pop_valid), 32'd0);
        chk("mid_pc", pc_from_memory, 32'd0);
        cycle();
        reset = 1'b1;
        cycle();
        do_load(16'd2047, ld); chk("mid_hi_kept", 32'(ld), 32'h0003);
        do_load(16'd2046, ld); chk("mid_lo_kept", 32'(ld), 32'h0004);
        chk("mid_sp_after", 32'(sp_out), 32'd2047);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
